// File: rtl/dcache_arb_pkg.sv
// -----------------------------------------------------------------------------
// dcache_arb_pkg
// Shared types and helpers for the D-cache request arbiter and its submodules.
//   idx_w()     : requester-index width, at least 1 bit even for one requester.
//   tag_pack()  : appends a requester index below a tag (index in the LSBs).
//   tag_idx()   : extracts the requester index from a packed tag.
//   tag_strip() : removes the requester index from a packed tag.
//   lane_req_t  : one request lane at the default core widths.
// The tag helpers work on 64-bit containers so they stay width-agnostic;
// callers zero-extend the inputs and slice the results to their real widths.
// -----------------------------------------------------------------------------
package dcache_arb_pkg;

  localparam int DEF_ADDR_W   = 30;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_TAG_IN_W = 16;

  typedef struct packed {
    logic                      rw;
    logic [DEF_ADDR_W-1:0]     addr;
    logic [DEF_DATA_W/8-1:0]   byteen;
    logic [DEF_DATA_W-1:0]     data;
    logic [DEF_TAG_IN_W-1:0]   tag;
  } lane_req_t;

  function automatic int idx_w(input int num_reqs);
    if (num_reqs > 1) begin
      return $clog2(num_reqs);
    end else begin
      return 1;
    end
  endfunction

  function automatic logic [63:0] tag_pack(input logic [63:0] tag,
                                           input logic [63:0] idx,
                                           input int          iw);
    logic [63:0] mask;
    mask = (64'd1 << iw) - 64'd1;
    return (tag << iw) | (idx & mask);
  endfunction

  function automatic logic [63:0] tag_idx(input logic [63:0] tag, input int iw);
    return tag & ((64'd1 << iw) - 64'd1);
  endfunction

  function automatic logic [63:0] tag_strip(input logic [63:0] tag, input int iw);
    return tag >> iw;
  endfunction

endpackage

// File: rtl/dcache_req_arbiter_if.sv
// -----------------------------------------------------------------------------
// dcache_req_arbiter_if
// Bundles the requester-side and cache-side request/response signals of the
// D-cache request arbiter.
//   in_req_*  / in_rsp_*  : requester side, per-requester packed arrays
//   out_req_* / out_rsp_* : D-cache side, per lane
// Modports:
//   slave  : the arbiter's view
//   master : the surrounding core's view (requesters + D-cache)
// -----------------------------------------------------------------------------
interface dcache_req_arbiter_if
  import dcache_arb_pkg::*;
#(
  parameter int NUM_REQS  = 2,
  parameter int NUM_LANES = 4,
  parameter int ADDR_W    = 30,
  parameter int DATA_W    = 32,
  parameter int TAG_IN_W  = 16
) ();

  localparam int IDX_W     = idx_w(NUM_REQS);
  localparam int OUT_TAG_W = TAG_IN_W + IDX_W;

  logic [NUM_REQS-1:0][NUM_LANES-1:0]                 in_req_valid;
  logic [NUM_REQS-1:0][NUM_LANES-1:0]                 in_req_rw;
  logic [NUM_REQS-1:0][NUM_LANES-1:0][ADDR_W-1:0]     in_req_addr;
  logic [NUM_REQS-1:0][NUM_LANES-1:0][DATA_W/8-1:0]   in_req_byteen;
  logic [NUM_REQS-1:0][NUM_LANES-1:0][DATA_W-1:0]     in_req_data;
  logic [NUM_REQS-1:0][NUM_LANES-1:0][TAG_IN_W-1:0]   in_req_tag;
  logic [NUM_REQS-1:0][NUM_LANES-1:0]                 in_req_ready;

  logic [NUM_LANES-1:0]                               out_req_valid;
  logic [NUM_LANES-1:0]                               out_req_rw;
  logic [NUM_LANES-1:0][ADDR_W-1:0]                   out_req_addr;
  logic [NUM_LANES-1:0][DATA_W/8-1:0]                 out_req_byteen;
  logic [NUM_LANES-1:0][DATA_W-1:0]                   out_req_data;
  logic [NUM_LANES-1:0][OUT_TAG_W-1:0]                out_req_tag;
  logic [NUM_LANES-1:0]                               out_req_ready;

  logic                                               out_rsp_valid;
  logic [NUM_LANES-1:0]                               out_rsp_tmask;
  logic [NUM_LANES-1:0][DATA_W-1:0]                   out_rsp_data;
  logic [OUT_TAG_W-1:0]                               out_rsp_tag;
  logic                                               out_rsp_ready;

  logic [NUM_REQS-1:0]                                in_rsp_valid;
  logic [NUM_LANES-1:0]                               in_rsp_tmask;
  logic [NUM_LANES-1:0][DATA_W-1:0]                   in_rsp_data;
  logic [TAG_IN_W-1:0]                                in_rsp_tag;
  logic [NUM_REQS-1:0]                                in_rsp_ready;

  modport slave (
    input  in_req_valid, in_req_rw, in_req_addr, in_req_byteen, in_req_data, in_req_tag,
    output in_req_ready,
    output out_req_valid, out_req_rw, out_req_addr, out_req_byteen, out_req_data, out_req_tag,
    input  out_req_ready,
    input  out_rsp_valid, out_rsp_tmask, out_rsp_data, out_rsp_tag,
    output out_rsp_ready,
    output in_rsp_valid, in_rsp_tmask, in_rsp_data, in_rsp_tag,
    input  in_rsp_ready
  );

  modport master (
    output in_req_valid, in_req_rw, in_req_addr, in_req_byteen, in_req_data, in_req_tag,
    input  in_req_ready,
    input  out_req_valid, out_req_rw, out_req_addr, out_req_byteen, out_req_data, out_req_tag,
    output out_req_ready,
    output out_rsp_valid, out_rsp_tmask, out_rsp_data, out_rsp_tag,
    input  out_rsp_ready,
    input  in_rsp_valid, in_rsp_tmask, in_rsp_data, in_rsp_tag,
    output in_rsp_ready
  );

endinterface

// File: rtl/dcache_req_arbiter_chk.sv
// -----------------------------------------------------------------------------
// dcache_req_arbiter_chk
// Protocol checks for dcache_req_arbiter (simulation only).
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   i_rsp_valid   : D-cache response valid
//   i_rsp_idx_ok  : response tag carries an index of an existing requester
// -----------------------------------------------------------------------------
module dcache_req_arbiter_chk (
  input logic clk,
  input logic reset,
  input logic i_rsp_valid,
  input logic i_rsp_idx_ok
);

  a_rsp_idx_legal: assert property (@(posedge clk) disable iff (reset)
                                    i_rsp_valid |-> i_rsp_idx_ok);

endmodule

// File: rtl/rr_lock_arbiter.sv
// -----------------------------------------------------------------------------
// rr_lock_arbiter
// Round-robin arbiter whose grant can be held across cycles while a
// multi-cycle transfer from the granted requester is still in flight.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   i_active   : per-requester "has something to send"
//   i_pending  : granted requester still has unaccepted work this cycle
//   o_grant    : granted requester index (combinational)
// -----------------------------------------------------------------------------
module rr_lock_arbiter
  import dcache_arb_pkg::*;
#(
  parameter  int NUM_REQS = 2,
  localparam int IDX_W    = idx_w(NUM_REQS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] i_active,
  input  logic                i_pending,
  output logic [IDX_W-1:0]    o_grant
);

  logic             r_locked_q;
  logic [IDX_W-1:0] r_grant_q;
  logic [IDX_W-1:0] r_rr_ptr_q;
  logic             w_locked_d;
  logic [IDX_W-1:0] w_grant_d;
  logic [IDX_W-1:0] w_rr_ptr_d;
  logic [IDX_W-1:0] w_pick;
  logic [IDX_W-1:0] w_grant;
  logic             w_found;
  logic             w_hit;
  logic             w_grant_active;

  // (base + off) mod NUM_REQS, valid because base < NUM_REQS and off < NUM_REQS
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    s = (s >= NUM_REQS) ? (s - NUM_REQS) : s;
    return IDX_W'(s);
  endfunction

  // State register: lock flag, held grant and round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      r_locked_q <= 1'b0;
      r_grant_q  <= {IDX_W{1'b0}};
      r_rr_ptr_q <= {IDX_W{1'b0}};
    end else begin
      r_locked_q <= w_locked_d;
      r_grant_q  <= w_grant_d;
      r_rr_ptr_q <= w_rr_ptr_d;
    end
  end

  // Output: held grant while locked, else first active requester from the pointer
  always_comb begin
    w_pick  = r_rr_ptr_q;
    w_found = 1'b0;
    w_hit   = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) begin
      w_hit   = ~w_found & i_active[wrap_add(r_rr_ptr_q, i)];
      w_pick  = w_hit ? wrap_add(r_rr_ptr_q, i) : w_pick;
      w_found = w_found | w_hit;
    end
    w_grant        = r_locked_q ? r_grant_q : w_pick;
    w_grant_active = i_active[w_grant];
  end

  // Next state: release and advance on completion, hold on partial accept,
  // release without advancing when the locked requester has dropped its batch
  always_comb begin
    w_locked_d = r_locked_q;
    w_grant_d  = r_grant_q;
    w_rr_ptr_d = r_rr_ptr_q;
    if (w_grant_active && !i_pending) begin
      w_locked_d = 1'b0;
      w_rr_ptr_d = wrap_add(w_grant, 1);
    end else if (w_grant_active) begin
      w_locked_d = 1'b1;
      w_grant_d  = w_grant;
    end else begin
      w_locked_d = 1'b0;
    end
  end

  assign o_grant = w_grant;

endmodule

// File: rtl/dcache_req_arbiter.sv
// -----------------------------------------------------------------------------
// dcache_req_arbiter
// Shares one per-lane D-cache request/response port between NUM_REQS
// requesters. A grant stays on one requester until its whole lane batch has
// been accepted; batches are arbitrated round-robin. The requester index is
// appended in the LSBs of the outgoing tag and stripped again on responses.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   bus (slave)       : requester and D-cache request/response signals
//   perf_stall_cycles : per-requester stall counters, only when the macro
//                       DCACHE_ARB_PERF_EN is defined
// Both paths are purely combinational; registered state only steers the
// next cycle's grant.
// -----------------------------------------------------------------------------
module dcache_req_arbiter
  import dcache_arb_pkg::*;
#(
  parameter int NUM_REQS  = 2,
  parameter int NUM_LANES = 4,
  parameter int ADDR_W    = 30,
  parameter int DATA_W    = 32,
  parameter int TAG_IN_W  = 16,
  parameter int CTR_W     = 44
) (
  input  logic               clk,
  input  logic               reset,
  dcache_req_arbiter_if.slave bus
`ifdef DCACHE_ARB_PERF_EN
  ,
  output logic [NUM_REQS-1:0][CTR_W-1:0] perf_stall_cycles
`endif
);

  localparam int IDX_W     = idx_w(NUM_REQS);
  localparam int OUT_TAG_W = TAG_IN_W + IDX_W;

  logic [NUM_REQS-1:0]                 w_active;
  logic [IDX_W-1:0]                    w_grant;
  logic [NUM_LANES-1:0]                w_pending;
  logic [NUM_LANES-1:0][ADDR_W-1:0]    w_sel_addr;
  logic [NUM_LANES-1:0][DATA_W-1:0]    w_sel_data;
  logic [NUM_LANES-1:0][63:0]          w_tag_pack;
  logic [63:0]                         w_rsp_tag64;
  logic [63:0]                         w_rsp_idx64;
  logic [63:0]                         w_rsp_strip;
  logic [IDX_W-1:0]                    w_rsp_idx;
  logic                                w_rsp_idx_ok;
  logic                                w_unused_bits;

  // Requester is active when any of its lanes is valid
  always_comb begin
    w_active = {NUM_REQS{1'b0}};
    for (int r = 0; r < NUM_REQS; r++) begin
      w_active[r] = |bus.in_req_valid[r];
    end
  end

  // Lanes of the granted batch the cache did not take this cycle
  assign w_pending = bus.in_req_valid[w_grant] & ~bus.out_req_ready;

  rr_lock_arbiter #(
    .NUM_REQS (NUM_REQS)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .i_active  (w_active),
    .i_pending (|w_pending),
    .o_grant   (w_grant)
  );

  // Request mux: the granted requester's lanes go straight to the cache
  assign w_sel_addr         = bus.in_req_addr[w_grant];
  assign w_sel_data         = bus.in_req_data[w_grant];
  assign bus.out_req_valid  = bus.in_req_valid[w_grant];
  assign bus.out_req_rw     = bus.in_req_rw[w_grant];
  assign bus.out_req_addr   = w_sel_addr;
  assign bus.out_req_byteen = bus.in_req_byteen[w_grant];
  assign bus.out_req_data   = w_sel_data;

  // Outgoing tag per lane: requester tag with the grant index below it
  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      w_tag_pack[l]      = tag_pack(64'(bus.in_req_tag[w_grant][l]), 64'(w_grant), IDX_W);
      bus.out_req_tag[l] = w_tag_pack[l][OUT_TAG_W-1:0];
    end
  end

  // Only the granted requester sees the cache's per-lane ready
  always_comb begin
    for (int r = 0; r < NUM_REQS; r++) begin
      if (w_grant == IDX_W'(r)) begin
        bus.in_req_ready[r] = bus.out_req_ready;
      end else begin
        bus.in_req_ready[r] = {NUM_LANES{1'b0}};
      end
    end
  end

  // Response routing by the index held in the tag LSBs
  assign w_rsp_tag64      = 64'(bus.out_rsp_tag);
  assign w_rsp_idx64      = tag_idx(w_rsp_tag64, IDX_W);
  assign w_rsp_idx        = w_rsp_idx64[IDX_W-1:0];
  assign w_rsp_idx_ok     = (w_rsp_idx64 < 64'(NUM_REQS));
  assign w_rsp_strip      = tag_strip(w_rsp_tag64, IDX_W);
  assign bus.in_rsp_tag   = w_rsp_strip[TAG_IN_W-1:0];
  assign bus.in_rsp_tmask = bus.out_rsp_tmask;
  assign bus.in_rsp_data  = bus.out_rsp_data;

  // Per-requester response valid, qualified by the decoded index
  always_comb begin
    for (int r = 0; r < NUM_REQS; r++) begin
      bus.in_rsp_valid[r] = bus.out_rsp_valid & (w_rsp_idx == IDX_W'(r));
    end
  end

  // Back-pressure from the addressed requester; an out-of-range index is drained
  always_comb begin
    if (w_rsp_idx_ok) begin
      bus.out_rsp_ready = bus.in_rsp_ready[w_rsp_idx];
    end else begin
      bus.out_rsp_ready = 1'b1;
    end
  end

  // Upper bits of the 64-bit helper containers are structurally zero
  assign w_unused_bits = ^{w_rsp_strip, w_tag_pack};

`ifdef DCACHE_ARB_PERF_EN
  logic [NUM_REQS-1:0][CTR_W-1:0] r_perf_stall_q;

  // Stall counters: active but not granted this cycle; wrap naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_stall_q <= {(NUM_REQS*CTR_W){1'b0}};
    end else begin
      for (int r = 0; r < NUM_REQS; r++) begin
        if (w_active[r] && (w_grant != IDX_W'(r))) begin
          r_perf_stall_q[r] <= r_perf_stall_q[r] + CTR_W'(1);
        end else begin
          r_perf_stall_q[r] <= r_perf_stall_q[r];
        end
      end
    end
  end

  assign perf_stall_cycles = r_perf_stall_q;
`else
  // Counter width is only meaningful when the counters are built
  logic [CTR_W-1:0] w_unused_ctr;
  assign w_unused_ctr = {CTR_W{1'b0}};
`endif

`ifndef SYNTHESIS
  dcache_req_arbiter_chk u_chk (
    .clk          (clk),
    .reset        (reset),
    .i_rsp_valid  (bus.out_rsp_valid),
    .i_rsp_idx_ok (w_rsp_idx_ok)
  );
`endif

endmodule

// File: tb/tb_dcache_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dcache_req_arbiter
// Directed bench for dcache_req_arbiter with two requesters and four lanes.
// Covers reset outputs, single-requester forwarding, partial accept and lock,
// round-robin alternation, lock release on dropped batch, reset mid-batch,
// response routing and, with DCACHE_ARB_PERF_EN, the stall counters.
// -----------------------------------------------------------------------------
module tb_dcache_req_arbiter;

  localparam int NUM_REQS  = 2;
  localparam int NUM_LANES = 4;
  localparam int ADDR_W    = 30;
  localparam int DATA_W    = 32;
  localparam int TAG_IN_W  = 16;
  localparam int CTR_W     = 44;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  dcache_req_arbiter_if #(
    .NUM_REQS (NUM_REQS), .NUM_LANES (NUM_LANES), .ADDR_W (ADDR_W),
    .DATA_W (DATA_W), .TAG_IN_W (TAG_IN_W)
  ) bus ();

`ifdef DCACHE_ARB_PERF_EN
  logic [NUM_REQS-1:0][CTR_W-1:0] perf_stall_cycles;
`endif

  dcache_req_arbiter #(
    .NUM_REQS (NUM_REQS), .NUM_LANES (NUM_LANES), .ADDR_W (ADDR_W),
    .DATA_W (DATA_W), .TAG_IN_W (TAG_IN_W), .CTR_W (CTR_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef DCACHE_ARB_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: state updates on the rising edge, inputs change at the falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input logic [3:0] v0, input logic [3:0] v1, input logic [3:0] rdy);
    bus.in_req_valid[0] = v0;
    bus.in_req_valid[1] = v1;
    bus.out_req_ready   = rdy;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    bus.in_req_valid  = '0;
    bus.out_req_ready = '0;
    bus.out_rsp_valid = 1'b0;
    bus.out_rsp_tmask = '0;
    bus.out_rsp_data  = '0;
    bus.out_rsp_tag   = '0;
    bus.in_rsp_ready  = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      bus.in_req_rw[0][l]     = 1'b0;
      bus.in_req_rw[1][l]     = 1'b1;
      bus.in_req_addr[0][l]   = 30'h100 + 30'(l);
      bus.in_req_addr[1][l]   = 30'h200 + 30'(l);
      bus.in_req_byteen[0][l] = 4'hF;
      bus.in_req_byteen[1][l] = 4'h3;
      bus.in_req_data[0][l]   = 32'hA000_0000 + 32'(l);
      bus.in_req_data[1][l]   = 32'hB000_0000 + 32'(l);
      bus.in_req_tag[0][l]    = 16'h1000 + 16'(l);
      bus.in_req_tag[1][l]    = 16'h2000 + 16'(l);
    end

    // Reset: all inputs idle, every valid and ready low
    tick();
    tick();
    #1;
    check_eq("rst_out_valid", 64'(bus.out_req_valid), 64'h0);
    check_eq("rst_in_ready",  64'(bus.in_req_ready),  64'h0);
    check_eq("rst_rsp_valid", 64'(bus.in_rsp_valid),  64'h0);
    check_eq("rst_rsp_ready", 64'(bus.out_rsp_ready), 64'h0);
    reset = 1'b0;
    tick();

    // Single requester, all lanes accepted at once
    set_req(4'b1111, 4'b0000, 4'b1111);
    check_eq("single_valid", 64'(bus.out_req_valid),   64'hF);
    check_eq("single_ready", 64'(bus.in_req_ready),    64'h0F);
    check_eq("single_tag0",  64'(bus.out_req_tag[0]),  64'h02000);
    check_eq("single_tag3",  64'(bus.out_req_tag[3]),  64'h02006);
    check_eq("single_addr2", 64'(bus.out_req_addr[2]), 64'h102);
    check_eq("single_data1", 64'(bus.out_req_data[1]), 64'hA000_0001);
    tick();
    set_req(4'b0000, 4'b0011, 4'b1111);
    check_eq("r1_valid",  64'(bus.out_req_valid),     64'h3);
    check_eq("r1_ready",  64'(bus.in_req_ready),      64'hF0);
    check_eq("r1_tag0",   64'(bus.out_req_tag[0]),    64'h04001);
    check_eq("r1_rw",     64'(bus.out_req_rw),        64'hF);
    check_eq("r1_byteen", 64'(bus.out_req_byteen[0]), 64'h3);
    tick();

    // Move pointer to r1, then partial accept from r0 locks it
    set_req(4'b0001, 4'b0000, 4'b1111);
    check_eq("pa_pre_ready", 64'(bus.in_req_ready), 64'h0F);
    tick();
    set_req(4'b1111, 4'b0000, 4'b0011);
    check_eq("pa_c0_valid", 64'(bus.out_req_valid), 64'hF);
    check_eq("pa_c0_ready", 64'(bus.in_req_ready),  64'h03);
    tick();
    set_req(4'b1100, 4'b0101, 4'b1111);
    check_eq("pa_c1_valid", 64'(bus.out_req_valid),  64'hC);
    check_eq("pa_c1_ready", 64'(bus.in_req_ready),   64'h0F);
    check_eq("pa_c1_tag2",  64'(bus.out_req_tag[2]), 64'h02004);
    tick();
    set_req(4'b0000, 4'b0101, 4'b1111);
    check_eq("pa_c2_valid", 64'(bus.out_req_valid), 64'h5);
    check_eq("pa_c2_ready", 64'(bus.in_req_ready),  64'hF0);
    tick();

    // Round robin with both requesters continuously active
    for (int c = 0; c < 4; c++) begin
      set_req(4'b1111, 4'b1111, 4'b1111);
      check_eq("rr_ready", 64'(bus.in_req_ready), (c % 2 == 0) ? 64'h0F : 64'hF0);
      check_eq("rr_data0", 64'(bus.out_req_data[0]),
               (c % 2 == 0) ? 64'hA000_0000 : 64'hB000_0000);
      tick();
    end

    // Locked requester withdraws its batch: lock drops, nothing forwarded
    set_req(4'b0000, 4'b1111, 4'b0000);
    check_eq("drop_c0_valid", 64'(bus.out_req_valid), 64'hF);
    check_eq("drop_c0_ready", 64'(bus.in_req_ready),  64'h00);
    tick();
    set_req(4'b0011, 4'b0000, 4'b1111);
    check_eq("drop_c1_valid", 64'(bus.out_req_valid), 64'h0);
    check_eq("drop_c1_ready", 64'(bus.in_req_ready),  64'hF0);
    tick();
    set_req(4'b0011, 4'b0000, 4'b1111);
    check_eq("drop_c2_ready", 64'(bus.in_req_ready), 64'h0F);
    tick();

    // Reset while r1 holds the lock
    set_req(4'b0000, 4'b1111, 4'b0001);
    check_eq("rmb_lock_ready", 64'(bus.in_req_ready), 64'h10);
    tick();
    set_req(4'b1111, 4'b1100, 4'b1111);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check_eq("rmb_after_ready", 64'(bus.in_req_ready),  64'h0F);
    check_eq("rmb_after_valid", 64'(bus.out_req_valid), 64'hF);
    tick();
    set_req(4'b0000, 4'b0000, 4'b0000);

    // Response routing
    bus.out_rsp_valid   = 1'b1;
    bus.out_rsp_tag     = {16'h00AB, 1'b1};
    bus.out_rsp_tmask   = 4'b1010;
    bus.out_rsp_data[3] = 32'hDEAD_BEEF;
    bus.in_rsp_ready    = 2'b01;
    #1;
    check_eq("rsp1_valid", 64'(bus.in_rsp_valid),   64'h2);
    check_eq("rsp1_tag",   64'(bus.in_rsp_tag),     64'h00AB);
    check_eq("rsp1_ready", 64'(bus.out_rsp_ready),  64'h0);
    check_eq("rsp1_tmask", 64'(bus.in_rsp_tmask),   64'hA);
    check_eq("rsp1_data3", 64'(bus.in_rsp_data[3]), 64'hDEAD_BEEF);
    bus.in_rsp_ready = 2'b10;
    #1;
    check_eq("rsp1_ready_hi", 64'(bus.out_rsp_ready), 64'h1);
    bus.out_rsp_tag  = {16'h1234, 1'b0};
    bus.in_rsp_ready = 2'b01;
    #1;
    check_eq("rsp0_valid", 64'(bus.in_rsp_valid),  64'h1);
    check_eq("rsp0_tag",   64'(bus.in_rsp_tag),    64'h1234);
    check_eq("rsp0_ready", 64'(bus.out_rsp_ready), 64'h1);
    bus.out_rsp_valid = 1'b0;
    #1;
    check_eq("rsp_idle_valid", 64'(bus.in_rsp_valid), 64'h0);

`ifdef DCACHE_ARB_PERF_EN
    // r0 holds the port for five cycles while r1 waits
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check_eq("perf_rst1", 64'(perf_stall_cycles[1]), 64'h0);
    set_req(4'b1111, 4'b1111, 4'b0000);
    for (int c = 0; c < 5; c++) begin
      tick();
    end
    set_req(4'b0000, 4'b0000, 4'b0000);
    check_eq("perf_stall1", 64'(perf_stall_cycles[1]), 64'h5);
    check_eq("perf_stall0", 64'(perf_stall_cycles[0]), 64'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
